// File: rtl/brent_chain_ctrl.sv
// Multi-chunk add/subtract sequencer for the shared 6-bit Brent-Kung adder.
// Streams operand chunks LSB first, chains the carry between chunks and
// returns result chunks through a single output register with valid/ready.
module brent_chain_ctrl #(
    parameter int unsigned W      = 6,
    parameter int unsigned NCHUNK = 4,
    parameter int unsigned LW     = $clog2(NCHUNK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [LW-1:0] cmd_len,
    input  logic          cmd_sub,
    input  logic          cmd_cin,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic [W-1:0]  add_a,
    output logic [W-1:0]  add_b,
    output logic          add_cin,
    input  logic [W:0]    add_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          carry_out,
    output logic          overflow
);

    // Counter is one bit wider than cmd_len so a full NCHUNK length is representable.
    localparam int unsigned CW = LW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  len_q, len_d;
    logic           sub_q, sub_d;
    logic           carry_q, carry_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_sum_q, out_sum_d;
    logic           out_last_q, out_last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           carry_out_q, carry_out_d;
    logic           overflow_q, overflow_d;
    logic           in_hs;
    logic           out_hs;
    logic           last_chunk;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state, handshakes and combinational adder drive.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        in_hs       = 1'b0;
        out_hs      = out_valid_q && out_ready;
        last_chunk  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && cmd_ready) begin
                    len_d       = (cmd_len == '0) ? CW'(NCHUNK) : CW'(cmd_len);
                    sub_d       = cmd_sub;
                    carry_d     = cmd_sub ? 1'b1 : cmd_cin;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = S_RUN;
                end
            end

            S_RUN: begin
                in_ready = !rst && (!out_valid_q || out_ready);
                add_a    = in_a;
                add_b    = sub_q ? ~in_b : in_b;
                add_cin  = carry_q;
                in_hs    = in_valid && in_ready;
                if (out_hs) begin
                    out_valid_d = 1'b0;
                end
                if (in_hs) begin
                    last_chunk  = (cnt_q == (len_q - CW'(1)));
                    out_sum_d   = add_res[W-1:0];
                    carry_d     = add_res[W];
                    out_valid_d = 1'b1;
                    out_last_d  = last_chunk;
                    cnt_d       = cnt_q + CW'(1);
                    if (last_chunk) begin
                        carry_out_d = add_res[W];
                        overflow_d  = (in_a[W-1] == add_b[W-1]) && (add_res[W-1] != in_a[W-1]);
                        state_d     = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_brent_chain_ctrl.sv
// Directed bench for brent_chain_ctrl with a behavioural model of the adder.
module tb_brent_chain_ctrl;

    localparam int unsigned W      = 6;
    localparam int unsigned NCHUNK = 4;
    localparam int unsigned LW     = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          cmd_sub;
    logic          cmd_cin;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W:0]    add_res;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          carry_out;
    logic          overflow;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Stand-in for the Brent-Kung adder: same-cycle sum with carry-out.
    assign add_res = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    brent_chain_ctrl #(.W(W), .NCHUNK(NCHUNK), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_sub(cmd_sub), .cmd_cin(cmd_cin),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_res(add_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_last(out_last), .busy(busy), .done(done),
        .carry_out(carry_out), .overflow(overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
        checks++; if ({out_valid, out_last, busy, done, carry_out, overflow} !== 6'b0) begin fails++; $display("FAIL rst_flags: got %b exp 000000", {out_valid, out_last, busy, done, carry_out, overflow}); end
        checks++; if (out_sum !== 6'h00) begin fails++; $display("FAIL rst_out_sum: got %h exp 00", out_sum); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_release_cmd_ready: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_add_chain();
        cmd_valid = 1'b1; cmd_len = 2'd2; cmd_sub = 1'b0; cmd_cin = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL add_busy: got %b exp 1", busy); end
        checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL add_cmd_ready_run: got %b exp 0", cmd_ready); end
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 6'h3F; in_b = 6'h01;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_in_ready: got %b exp 1", in_ready); end
        checks++; if (add_cin !== 1'b0) begin fails++; $display("FAIL add_cin0: got %b exp 0", add_cin); end
        tick();
        in_a = 6'h01; in_b = 6'h00;
        #1;
        checks++; if (out_valid !== 1'b1 || out_sum !== 6'h00 || out_last !== 1'b0) begin fails++; $display("FAIL add_chunk0: got v%b %h l%b exp v1 00 l0", out_valid, out_sum, out_last); end
        checks++; if (add_cin !== 1'b1) begin fails++; $display("FAIL add_cin_chain: got %b exp 1", add_cin); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_sum !== 6'h02 || out_last !== 1'b1) begin fails++; $display("FAIL add_chunk1: got v%b %h l%b exp v1 02 l1", out_valid, out_sum, out_last); end
        checks++; if (carry_out !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL add_flags: got c%b o%b exp c0 o0", carry_out, overflow); end
        checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL add_drain: got ir%b d%b exp ir0 d0", in_ready, done); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin fails++; $display("FAIL add_done: got d%b b%b v%b l%b exp d1 b0 v0 l0", done, busy, out_valid, out_last); end
        tick();
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL add_done_pulse: got %b exp 0", done); end
    endtask

    task automatic test_sub();
        cmd_valid = 1'b1; cmd_len = 2'd1; cmd_sub = 1'b1; cmd_cin = 1'b0;
        tick();
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 6'h05; in_b = 6'h07;
        #1;
        checks++; if (add_b !== 6'h38 || add_cin !== 1'b1 || add_a !== 6'h05) begin fails++; $display("FAIL sub_drive: got a%h b%h c%b exp a05 b38 c1", add_a, add_b, add_cin); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_sum !== 6'h3E || out_last !== 1'b1) begin fails++; $display("FAIL sub_sum: got %h l%b exp 3e l1", out_sum, out_last); end
        checks++; if (carry_out !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL sub_flags: got c%b o%b exp c0 o0", carry_out, overflow); end
        tick();
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL sub_done: got %b exp 1", done); end
        tick();
    endtask

    task automatic test_overflow();
        cmd_valid = 1'b1; cmd_len = 2'd1; cmd_sub = 1'b0; cmd_cin = 1'b0;
        tick();
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 6'h1F; in_b = 6'h01;
        tick();
        in_valid = 1'b0;
        checks++; if (out_sum !== 6'h20) begin fails++; $display("FAIL ovf_sum: got %h exp 20", out_sum); end
        checks++; if (carry_out !== 1'b0 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_flags: got c%b o%b exp c0 o1", carry_out, overflow); end
        tick();
        tick();
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_hold_idle: got %b exp 1", overflow); end
    endtask

    task automatic test_backpressure();
        cmd_valid = 1'b1; cmd_len = 2'd2; cmd_sub = 1'b0; cmd_cin = 1'b0;
        tick();
        cmd_valid = 1'b0;
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL bp_ovf_clear: got %b exp 0", overflow); end
        in_valid = 1'b1; in_a = 6'h3F; in_b = 6'h01;
        tick();
        out_ready = 1'b0;
        in_a = 6'h01; in_b = 6'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_%0d: got %b exp 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_sum !== 6'h00) begin fails++; $display("FAIL bp_hold_%0d: got v%b %h exp v1 00", i, out_valid, out_sum); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_sum !== 6'h02 || out_last !== 1'b1 || carry_out !== 1'b0) begin fails++; $display("FAIL bp_final: got %h l%b c%b exp 02 l1 c0", out_sum, out_last, carry_out); end
        tick();
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done: got %b exp 1", done); end
        tick();
    endtask

    task automatic test_full_len();
        cmd_valid = 1'b1; cmd_len = 2'd0; cmd_sub = 1'b0; cmd_cin = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 6'h3F; in_b = 6'h00;
            tick();
            if (i == 3) in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_sum !== 6'h00 || out_last !== (i == 3)) begin fails++; $display("FAIL full_chunk%0d: got v%b %h l%b exp v1 00 l%b", i, out_valid, out_sum, out_last, (i == 3)); end
            checks++; if (busy !== 1'b1) begin fails++; $display("FAIL full_busy%0d: got %b exp 1", i, busy); end
        end
        checks++; if (carry_out !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL full_flags: got c%b o%b exp c1 o0", carry_out, overflow); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL full_done: got d%b b%b exp d1 b0", done, busy); end
        tick();
    endtask

    task automatic test_midop_reset();
        cmd_valid = 1'b1; cmd_len = 2'd3; cmd_sub = 1'b0; cmd_cin = 1'b0;
        tick();
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 6'h01; in_b = 6'h01;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_sum !== 6'h02) begin fails++; $display("FAIL mr_chunk0: got v%b %h exp v1 02", out_valid, out_sum); end
        rst = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL mr_ready_in_rst: got c%b i%b exp c0 i0", cmd_ready, in_ready); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mr_cleared: got v%b b%b d%b exp v0 b0 d0", out_valid, busy, done); end
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL mr_cmd_ready: got %b exp 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_len = 2'd1; cmd_sub = 1'b0; cmd_cin = 1'b0;
        tick();
        cmd_valid = 1'b0;
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL mr_no_done: got %b exp 0", done); end
        in_valid = 1'b1; in_a = 6'h02; in_b = 6'h03;
        tick();
        in_valid = 1'b0;
        checks++; if (out_sum !== 6'h05 || out_last !== 1'b1) begin fails++; $display("FAIL mr_next_op: got %h l%b exp 05 l1", out_sum, out_last); end
        tick();
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL mr_next_done: got %b exp 1", done); end
        tick();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_sub = 1'b0; cmd_cin = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        test_reset();
        test_add_chain();
        test_sub();
        test_overflow();
        test_backpressure();
        test_full_len();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/brent_chain_ctrl.md
Name: brent_chain_ctrl

Overview:
Sequencer that runs multi-chunk add/subtract operations through the shared 6-bit Brent-Kung adder, one chunk per cycle, LSB chunk first. It accepts a command, streams operand chunks in, drives the adder's A/B/Cin, and captures sum and carry. It chains the carry between chunks and streams result chunks out with valid/ready backpressure. It sits between the top-level I/O mux/demux and the brent_kung_cin instance.

Parameters:
W, 6, chunk width (matches adder operand width)
NCHUNK, 4, maximum chunks per operation (power of 2)
LW, $clog2(NCHUNK), width of cmd_len

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_len  in  LW  chunk count; 0 means NCHUNK
cmd_sub  in  1  1 = A-B, 0 = A+B
cmd_cin  in  1  carry-in for chunk 0 when cmd_sub=0
in_valid  in  1  operand chunk offered
in_ready  out  1  operand chunk accepted when both high
in_a  in  W  operand A chunk
in_b  in  W  operand B chunk
add_a  out  W  to adder A
add_b  out  W  to adder B
add_cin  out  1  to adder Cin
add_res  in  W+1  from adder, combinational same cycle; [W-1:0] sum, [W] carry-out
out_valid  out  1  result chunk valid
out_ready  in  1  result chunk accepted when both high
out_sum  out  W  result chunk
out_last  out  1  marks final result chunk
busy  out  1  operation in progress
done  out  1  one-cycle pulse at operation end
carry_out  out  1  final carry; for subtract, 1 = no borrow
overflow  out  1  signed overflow of full-width result

Behaviour:
- Reset (rst high at clk edge): state=IDLE; out_valid, out_sum, out_last, busy, done, carry_out, overflow, chunk counter, and carry register all 0. cmd_ready and in_ready are forced low while rst is high. Any partial operation is dropped and no done is issued.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: cmd_ready=1, in_ready=0, add_a=add_b=0, add_cin=0.
  - On command handshake: latch len, sub, and the effective length (len=0 gives NCHUNK). Set the carry register to cmd_sub ? 1 : cmd_cin. Set counter=0, busy=1, and go to RUN.
  - carry_out and overflow are held from the previous operation until this handshake, then cleared.
- RUN: cmd_ready=0. in_ready = !out_valid || out_ready (single output register, no skid). Adder drive is combinational: add_a=in_a, add_b = sub ? ~in_b : in_b, add_cin = carry register.
- On an input handshake:
  - out_sum <= add_res[W-1:0]; carry register <= add_res[W]; out_valid <= 1; counter++.
  - out_last <= 1 when counter == effective length-1. On that last chunk: carry_out <= add_res[W]; overflow <= (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the post-inversion B. Then go to DRAIN.
- Output register: out_valid is cleared on an output handshake unless a new input handshake occurs in the same cycle. Result latency is 1 cycle after the input handshake. Throughput is 1 chunk/cycle while out_ready=1.
- out_sum and out_last hold stable while out_valid=1 and out_ready=0. The carry register advances only on an input handshake, so backpressure never double-counts a carry.
- DRAIN: in_ready=0. When the final chunk is accepted (out handshake with out_last=1), the next cycle has state=IDLE, busy=0, out_valid=0, out_last=0, and done=1 for exactly one cycle.
- cmd_valid during RUN/DRAIN is ignored (cmd_ready=0). in_valid in IDLE/DRAIN is ignored.
- Counter is LW+1 bits so that len=NCHUNK compares correctly; no wrap within an operation.

Test Plan:
- Add, len=2, cin=0, A chunks (0x3F, 0x01), B chunks (0x01, 0x00), out_ready=1 -> out_sum 0x00 then 0x02 (out_last on second); carry_out=0, overflow=0; done one cycle after the last out handshake.
- Subtract, len=1, A=0x05, B=0x07 -> add_b=0x38, add_cin=1, out_sum=0x3E, carry_out=0 (borrow), overflow=0.
- Add, len=1, A=0x1F, B=0x01, cin=0 -> out_sum=0x20, carry_out=0, overflow=1.
- Repeat the first scenario with out_ready low for 3 cycles after the first result -> in_ready=0 and out_sum held at 0x00 during the stall; final results identical (0x00, 0x02, carry_out=0).
- len=0 (4 chunks), all A=0x3F, B=0x00, cin=1 -> four outputs of 0x00, out_last on the 4th, carry_out=1, busy high for the whole operation.
- Assert rst for 1 cycle after the first chunk of a len=3 add -> out_valid=0, busy=0, no done pulse; cmd_ready=1 the cycle after rst drops; a following len=1 add 0x02+0x03 gives 0x05.
